// File: rtl/mem_pkg.sv
// mem_pkg: shared size encodings, FSM states and timeout default for the memory stage
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int DEF_TIMEOUT = 16;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-enable generation, store replication, load shift/extend and misalign detect
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);
  logic [31:0] w_shift;
  always_comb begin
    w_shift = i_rdata >> {i_off, 3'b000};
    o_be = (i_size == SZ_BYTE) ? 4'b0001 << i_off : (i_size == SZ_HALF) ? 4'b0011 << i_off : 4'b1111;
    o_wdata = (i_size == SZ_BYTE) ? {4{i_wdata[7:0]}} : (i_size == SZ_HALF) ? {2{i_wdata[15:0]}} : i_wdata;
    o_rdata = (i_size == SZ_BYTE) ? {{24{i_signed & w_shift[7]}}, w_shift[7:0]} :
              (i_size == SZ_HALF) ? {{16{i_signed & w_shift[15]}}, w_shift[15:0]} : w_shift;
    o_misalign = (i_size == SZ_BYTE) ? 1'b0 : (i_size == SZ_HALF) ? i_off[0] : |i_off;
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: turns EX/MEM load/store controls into a req/ack data-memory transaction with pipeline stall
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_MemRead,
  input  logic        in_MemWrite,
  input  logic [1:0]  in_size,
  input  logic        in_signed,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] MemRd,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err
);
  mem_state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic w_access, w_mis, w_start, w_timeout, w_end;
  logic [3:0] w_be;
  logic [31:0] w_wdata, w_rdata;
  mem_lane_align u_align (
    .i_size(in_size),
    .i_off(in_addr[1:0]),
    .i_signed(in_signed),
    .i_wdata(in_wdata),
    .i_rdata(dm_rdata),
    .o_be(w_be),
    .o_wdata(w_wdata),
    .o_rdata(w_rdata),
    .o_misalign(w_mis)
  );
  always_comb begin
    w_access = in_valid & (in_MemRead | in_MemWrite);
    w_start = (r_state == IDLE) & w_access & ~w_mis;
    w_timeout = r_cnt == CNT_W'(TIMEOUT - 1);
    w_end = (r_state == WAIT) & (dm_ack | w_timeout);
    w_next = (r_state == IDLE) ? (w_start ? WAIT : IDLE) :
             (r_state == WAIT) ? (w_end ? DONE : WAIT) : IDLE;
    stall = w_start | (r_state == WAIT);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      dm_req <= 1'b0;
      dm_we <= 1'b0;
      dm_addr <= '0;
      dm_be <= '0;
      dm_wdata <= '0;
      MemRd <= '0;
      misalign <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
      misalign <= (r_state == IDLE) & w_access & w_mis;
      bus_err <= (r_state == WAIT) & ~dm_ack & w_timeout;
      if (w_start) begin
        dm_req <= 1'b1;
        dm_we <= in_MemWrite;
        dm_addr <= {in_addr[31:2], 2'b00};
        dm_be <= w_be;
        dm_wdata <= w_wdata;
      end
      if (w_end) begin
        dm_req <= 1'b0;
        if (!dm_we) MemRd <= dm_ack ? w_rdata : '0;
      end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized and directed checks of mem_access_stage against a byte-level reference model
module tb_mem_access_stage;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_MemRead = 0, in_MemWrite = 0, in_signed = 0;
  logic [1:0] in_size = 0;
  logic [31:0] in_addr = 0, in_wdata = 0;
  logic dm_req, dm_we, dm_ack = 0, stall, misalign, bus_err;
  logic [31:0] dm_addr, dm_wdata, dm_rdata = 0, MemRd;
  logic [3:0] dm_be;
  int n_vec = 0, n_err = 0;
  logic [31:0] m_memrd = 0;

  mem_access_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_MemRead(in_MemRead),
    .in_MemWrite(in_MemWrite), .in_size(in_size), .in_signed(in_signed),
    .in_addr(in_addr), .in_wdata(in_wdata), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .MemRd(MemRd), .stall(stall), .misalign(misalign),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_be(input int n, input int off);
    logic [3:0] be = 0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + n) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wd(input int n, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_ld(input int n, input int off, input logic sg, input logic [31:0] rd);
    longint v, mask;
    mask = (64'd1 << (8 * n)) - 1;
    v = (longint'(rd) >> (8 * off)) & mask;
    if (sg && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic txn(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat, input int d);
    int n, off, w, stalls, expw;
    logic mis, acked;
    n = nbytes(sz);
    off = int'(a[1:0]);
    mis = (off % n) != 0;
    acked = d >= 0 && d < 16;
    expw = acked ? d + 1 : 16;
    in_valid = 1; in_MemRead = rd; in_MemWrite = wr; in_size = sz; in_signed = sg;
    in_addr = a; in_wdata = wd; dm_ack = 0; dm_rdata = $urandom;
    #1;
    chk("stall_start", stall, !mis);
    if (mis) begin
      @(negedge clk);
      in_valid = 0;
      #1;
      chk("misalign_pulse", misalign, 1);
      chk("misalign_req", dm_req, 0);
      chk("misalign_stall", stall, 0);
      @(negedge clk);
      chk("misalign_clear", misalign, 0);
      chk("misalign_memrd", MemRd, m_memrd);
      return;
    end
    stalls = 1;
    @(negedge clk);
    for (w = 0; w < 40 && dm_req; w++) begin
      chk("wait_addr", dm_addr, {a[31:2], 2'b00});
      chk("wait_be", dm_be, exp_be(n, off));
      chk("wait_we", dm_we, wr);
      if (wr) chk("wait_wdata", dm_wdata, exp_wd(n, wd));
      chk("wait_stall", stall, 1);
      stalls += int'(stall);
      if (w == d) begin dm_ack = 1; dm_rdata = rdat; end
      else dm_rdata = $urandom;
      @(negedge clk);
      dm_ack = 0;
    end
    chk("wait_cycles", w, expw);
    chk("stall_cycles", stalls, expw + 1);
    chk("done_req", dm_req, 0);
    chk("done_stall", stall, 0);
    chk("done_bus_err", bus_err, !acked);
    if (!wr) m_memrd = acked ? exp_ld(n, off, sg, rdat) : 32'h0;
    chk("done_memrd", MemRd, m_memrd);
    in_valid = 0;
    @(negedge clk);
    chk("idle_bus_err", bus_err, 0);
    chk("idle_stall", stall, 0);
    chk("idle_memrd", MemRd, m_memrd);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", dm_req, 0);
    chk("rst_we", dm_we, 0);
    chk("rst_be", dm_be, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0);
    chk("rst_memrd", MemRd, 0);
    chk("rst_flags", {misalign, bus_err, stall}, 0);
    reset = 0;
    @(negedge clk);
    txn(1, 0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 0);
    chk("plan_word_load", MemRd, 32'hDEADBEEF);
    txn(1, 0, 2'b00, 1, 32'h103, 0, 32'h80123456, 0);
    chk("plan_sbyte", MemRd, 32'hFFFFFF80);
    txn(1, 0, 2'b00, 0, 32'h103, 0, 32'h80123456, 0);
    chk("plan_ubyte", MemRd, 32'h00000080);
    txn(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h0, 3);
    chk("plan_half_store", MemRd, 32'h00000080);
    txn(1, 0, 2'b10, 0, 32'h101, 0, 32'h0, 0);
    txn(1, 0, 2'b10, 0, 32'h40, 0, 32'h12345678, -1);
    chk("plan_timeout", MemRd, 32'h0);
    txn(1, 1, 2'b11, 1, 32'h44, 32'hCAFEF00D, 32'h0, 1);
    dm_ack = 1; dm_rdata = 32'h55AA55AA;
    @(negedge clk);
    chk("stray_ack_memrd", MemRd, m_memrd);
    chk("stray_ack_req", dm_req, 0);
    dm_ack = 0;
    txn(1, 0, 2'b10, 0, 32'h300, 0, 32'h11223344, 0);
    in_valid = 1; in_MemRead = 1; in_MemWrite = 0; in_size = 2'b10; in_addr = 32'h400;
    @(negedge clk);
    chk("pre_rst_req", dm_req, 1);
    #2 reset = 1;
    #1;
    chk("async_rst_req", dm_req, 0);
    chk("async_rst_memrd", MemRd, 0);
    in_valid = 0;
    #1;
    chk("async_rst_stall", stall, 0);
    m_memrd = 0;
    dm_ack = 1; dm_rdata = 32'hFEEDFACE;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("late_ack_memrd", MemRd, 0);
    chk("late_ack_req", dm_req, 0);
    chk("late_ack_stall", stall, 0);
    dm_ack = 0;
    for (int k = 0; k < 300; k++) begin
      logic [1:0] op;
      int d;
      op = 2'($urandom_range(1, 3));
      d = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 6);
      txn(op[0], op[1], 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom, $urandom, d);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-stage access unit between the EX/MEM pipeline register and the MEM/WB register.
- Turns the EX/MEM load/store controls into a req/ack transaction on the data-memory bus, performing byte-lane steering and load sign/zero extension.
- Produces the load data that MEM/WB latches as its memory-read input.
- Drives the pipeline stall that gates the enables of the upstream registers and of MEM/WB while an access is outstanding.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles without dm_ack before the access is aborted. Must be ≥2.
- CNT_W, 5: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock. All state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX/MEM slot holds a live instruction.
- in_MemRead  in  1  instruction is a load.
- in_MemWrite  in  1  instruction is a store.
- in_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- in_signed  in  1  load is sign-extended (1) or zero-extended (0).
- in_addr  in  32  byte address (ALU result).
- in_wdata  in  32  store data, right-aligned.
- dm_req  out  1  bus request.
- dm_we  out  1  write strobe.
- dm_addr  out  32  word-aligned address, {in_addr[31:2],2'b00}.
- dm_be  out  4  byte enables.
- dm_wdata  out  32  lane-steered store data.
- dm_ack  in  1  bus completion; dm_rdata is valid in the same cycle.
- dm_rdata  in  32  read word.
- MemRd  out  32  formatted load result, fed to the MEM/WB memory-read input.
- stall  out  1  freezes the upstream pipeline and MEM/WB.
- misalign  out  1  one-cycle pulse: misaligned access rejected.
- bus_err  out  1  one-cycle pulse: access timed out.

Behaviour:
- Reset values: state IDLE; dm_req, dm_we, dm_be, dm_addr, dm_wdata = 0; MemRd = 0; misalign, bus_err = 0; counter = 0. Reset mid-access drops dm_req immediately, with no completion.
- Access condition: access = in_valid & (in_MemRead | in_MemWrite). When both read and write are set, the access is a store.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - access & aligned: register dm_* outputs, dm_req=1 next cycle, go to WAIT.
  - access & misaligned: pulse misalign next cycle, no bus request, stay in IDLE.
- WAIT:
  - dm_req held high; dm_addr, dm_we, dm_be, dm_wdata held stable.
  - Counter increments each cycle.
  - dm_ack: drop dm_req. For a load, register the formatted dm_rdata into MemRd. Go to DONE.
  - Counter reaches TIMEOUT without ack: drop dm_req, pulse bus_err, set MemRd=0 if the access is a load, go to DONE.
- DONE: ignore inputs (the instruction is still the old one). Return to IDLE next cycle.
- stall is combinational: stall = (state==IDLE & access & aligned) | (state==WAIT). It is low in DONE, so the pipeline advances exactly once per access.
- Latency: with ack on the first request cycle, stall is high for 2 cycles and MemRd is valid in the DONE cycle, 2 cycles after the start.
- dm_be: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
- dm_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load formatting: shifted = dm_rdata >> (8*addr[1:0]). Keep 8, 16 or 32 bits, then sign- or zero-extend per in_signed.
- MemRd holds its value across stores, misaligned accesses and idle cycles.
- dm_ack outside WAIT is ignored.

Decomposition:
- Package mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state enum mem_state_t {IDLE, WAIT, DONE};
  - the TIMEOUT default.
- Sub-module mem_lane_align is purely combinational and holds all lane logic (be generation, store replication, load shift/extend, misalign detect).
- FSM, counter and registers live in the top module.

Test Plan:
- Word load at 0x100, dm_rdata=0xDEADBEEF, ack on first WAIT cycle -> dm_addr=0x100, dm_be=1111, stall high 2 cycles, MemRd=0xDEADBEEF in DONE.
- Signed byte load at 0x103, dm_rdata=0x80123456 -> dm_be=1000, MemRd=0xFFFFFF80. Unsigned variant -> MemRd=0x00000080.
- Half store of 0x0000ABCD at 0x202 with ack delayed 3 cycles -> dm_we=1, dm_be=1100, dm_wdata=0xABCDABCD, signals stable throughout WAIT, stall high 5 cycles, MemRd unchanged.
- Word load at 0x101 -> misalign pulse, dm_req never asserted, stall=0.
- Load with no ack -> bus_err pulses after 16 WAIT cycles, dm_req drops, MemRd=0, FSM passes through DONE to IDLE.
- reset asserted mid-WAIT (async, between clock edges) -> dm_req=0 immediately, state IDLE, MemRd=0. A late ack is ignored.
